// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding constants and types for the instruction encoder and
// any decoder that reads the words it writes to instruction memory.
package legv8_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_ORR  = 3'd3,
    OP_LDUR = 3'd4,
    OP_STUR = 3'd5,
    OP_CBZ  = 3'd6,
    OP_INV  = 3'd7
  } op_t;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

  localparam int IMEM_DEPTH = 64;
  localparam int ADDR_W     = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

endpackage

// File: rtl/instr_pack.sv
// Pure combinational LEGv8 field packing plus legality check for one request.
module instr_pack
  import legv8_pkg::*;
(
  input  op_t         op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [18:0] imm,
  output logic [31:0] word,
  output logic        invalid
);

  // D-format offsets must fit a signed 9-bit field: upper bits are pure sign extension.
  logic dt_in_range;
  assign dt_in_range = (imm[18:8] == '0) || (imm[18:8] == '1);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    word    = '0;
    invalid = 1'b0;
    unique case (op)
      OP_ADD:  word = {OPC_ADD, rm, 6'b0, rn, rd};
      OP_SUB:  word = {OPC_SUB, rm, 6'b0, rn, rd};
      OP_AND:  word = {OPC_AND, rm, 6'b0, rn, rd};
      OP_ORR:  word = {OPC_ORR, rm, 6'b0, rn, rd};
      OP_LDUR: begin
        word    = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
        invalid = !dt_in_range;
      end
      OP_STUR: begin
        word    = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
        invalid = !dt_in_range;
      end
      OP_CBZ:  word = {OPC_CBZ, imm, rd};
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Session-based LEGv8 instruction encoder: packs requests into 32-bit words and
// streams them with sequential imem addresses until the 64-word image is full.
module instr_encoder
  import legv8_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  op_t         in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rn,
  input  logic [4:0]  in_rm,
  input  logic [18:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [5:0]  out_addr,
  output logic        full,
  output logic        err
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] count;
  logic [31:0]       word;
  logic              invalid;
  logic              accept, load, last;

  instr_pack u_pack (
    .op      (in_op),
    .rd      (in_rd),
    .rn      (in_rn),
    .rm      (in_rm),
    .imm     (in_imm),
    .word    (word),
    .invalid (invalid)
  );

  assign accept = in_valid && in_ready;
  assign load   = accept && !invalid;
  assign last   = (count == ADDR_W'(IMEM_DEPTH - 1));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (start) state_next = ST_ACTIVE;
      ST_ACTIVE: if (!start && load && last) state_next = ST_FULL;
      ST_FULL:   if (start) state_next = ST_ACTIVE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_ACTIVE) && !start && (!out_valid || out_ready);
    full     = (state == ST_FULL);
  end

  // Output register, address counter and sticky error; start discards any pending word.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else if (start) begin
      out_valid <= 1'b0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_instr <= word;
        out_addr  <= count;
        if (!last) count <= count + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && invalid) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed scenarios plus randomized traffic
// checked against an arithmetic reference model of the LEGv8 encodings.
module tb_instr_encoder;
  import legv8_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  op_t         in_op = OP_ADD;
  logic [4:0]  in_rd = '0, in_rn = '0, in_rm = '0;
  logic [18:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [5:0]  out_addr;
  logic        full;
  logic        err;

  instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rn     (in_rn),
    .in_rm     (in_rm),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .full      (full),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  addr;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cnt = 0;        // valid words accepted since the last start
  bit   exp_err = 1'b0;
  int   ready_mode = 0; // 0: always ready, 1: random, 2: stalled

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from the field layouts with integer arithmetic.
  function automatic bit model(input op_t op, input int rd, input int rn, input int rm,
                               input int imm, output logic [31:0] w);
    longint v;
    int     opc;
    v = 0;
    w = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        opc = (op == OP_ADD) ? 1112 : (op == OP_SUB) ? 1624 : (op == OP_AND) ? 1104 : 1360;
        v = longint'(opc) * 2097152 + rm * 65536 + rn * 32 + rd;
      end
      OP_LDUR, OP_STUR: begin
        if (imm < -256 || imm > 255) return 1'b0;
        opc = (op == OP_LDUR) ? 1986 : 1984;
        v = longint'(opc) * 2097152 + ((imm + 512) % 512) * 4096 + rn * 32 + rd;
      end
      OP_CBZ: v = longint'(180) * 16777216 + ((imm + 524288) % 524288) * 32 + rd;
      default: return 1'b0;
    endcase
    w = v[31:0];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every output handshake and checks hold stability.
  bit          prev_hold = 1'b0;
  logic [31:0] prev_instr;
  logic [5:0]  prev_addr;
  always @(negedge clk) begin
    exp_t e;
    if (prev_hold) begin
      check("hold_valid", out_valid, 1);
      check("hold_instr", out_instr, prev_instr);
      check("hold_addr", out_addr, prev_addr);
    end
    if (!reset && out_valid && out_ready) begin
      check("out_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("sb_instr", out_instr, e.instr);
        check("sb_addr", out_addr, e.addr);
      end
    end
    prev_hold  = !reset && !start && out_valid && !out_ready;
    prev_instr = out_instr;
    prev_addr  = out_addr;
  end

  // All tasks start and end at posedge+1.
  task automatic send(input op_t op, input int rd, input int rn, input int rm, input int imm);
    bit          got;
    bit          ok;
    logic [31:0] w;
    logic [31:0] imm_bits;
    imm_bits = imm;
    in_op    = op;
    in_rd    = rd[4:0];
    in_rn    = rn[4:0];
    in_rm    = rm[4:0];
    in_imm   = imm_bits[18:0];
    in_valid = 1'b1;
    got = 1'b0;
    ok  = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        ok  = model(op, rd, rn, rm, imm, w);
        if (ok) begin
          q.push_back('{instr: w, addr: 6'(cnt)});
          cnt++;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_accepted", got, 1);
    if (got && !ok) exp_err = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    check("start_blocks_ready", in_ready, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    q.delete();
    cnt = 0;
    exp_err = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) step();
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_instr", out_instr, 0);
    check("rst_addr", out_addr, 0);
    check("rst_err", err, 0);
    check("rst_full", full, 0);
    check("rst_ready", in_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    // Basic R-format
    do_start();
    send(OP_ADD, 1, 2, 3, 0);
    @(negedge clk);
    check("add_valid", out_valid, 1);
    check("add_instr", out_instr, 32'h8B030041);
    check("add_addr", out_addr, 0);
    step();

    // D-format and CBZ
    do_start();
    send(OP_LDUR, 4, 5, 0, 8);
    @(negedge clk);
    check("ldur_instr", out_instr, 32'hF84080A4);
    check("ldur_addr", out_addr, 0);
    step();
    send(OP_CBZ, 7, 0, 0, -2);
    @(negedge clk);
    check("cbz_instr", out_instr, 32'hB4FFFFC7);
    check("cbz_addr", out_addr, 1);
    step();

    // Out-of-range D offset is consumed silently but flags err
    send(OP_LDUR, 4, 5, 0, 300);
    @(negedge clk);
    check("inv_no_valid", out_valid, 0);
    check("inv_err", err, 1);
    step();
    send(OP_ADD, 1, 2, 3, 0);
    @(negedge clk);
    check("inv_addr_unadvanced", out_addr, 2);
    check("err_sticky", err, 1);
    step();
    do_start();
    @(negedge clk);
    check("err_cleared", err, 0);
    step();

    // Backpressure
    ready_mode = 2;
    repeat (2) step();
    send(OP_ADD, 1, 2, 3, 0);
    in_op = OP_SUB; in_rd = 5'd6; in_rn = 5'd7; in_rm = 5'd8; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready_low", in_ready, 0);
      step();
    end
    ready_mode = 0;
    send(OP_SUB, 6, 7, 8, 0);
    @(negedge clk);
    check("bp_second_instr", out_instr, 32'hCB0800E6);
    check("bp_second_addr", out_addr, 1);
    step();

    // Randomized traffic
    ready_mode = 1;
    do_start();
    for (int i = 0; i < 200; i++) begin
      op_t op;
      int  imm;
      op  = op_t'($urandom_range(0, 7));
      imm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 524287)) - 262144
                                        : int'($urandom_range(0, 600)) - 300;
      send(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), imm);
      check("rand_err", err, exp_err);
      if (cnt >= 60 || $urandom_range(0, 19) == 0) do_start();
    end

    // Fill the whole image
    ready_mode = 0;
    step();
    do_start();
    for (int i = 0; i < 64; i++) send(OP_ORR, i % 32, 3, 4, 0);
    @(negedge clk);
    check("full_set", full, 1);
    check("full_ready_low", in_ready, 0);
    check("full_last_addr", out_addr, 63);
    check("full_last_valid", out_valid, 1);
    step();
    do_start();
    @(negedge clk);
    check("full_cleared", full, 0);
    step();
    send(OP_ADD, 1, 2, 3, 0);
    @(negedge clk);
    check("restart_addr", out_addr, 0);
    step();

    // Reset while a word is stalled
    ready_mode = 2;
    repeat (2) step();
    send(OP_ADD, 9, 9, 9, 0);
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    step();
    reset = 1'b1;
    in_op = OP_ADD; in_valid = 1'b1;
    step();
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_full", full, 0);
    check("midrst_addr", out_addr, 0);
    step();
    reset = 1'b0;
    q.delete();
    cnt = 0;
    exp_err = 1'b0;
    step();
    @(negedge clk);
    check("idle_ready_low", in_ready, 0);
    check("idle_no_valid", out_valid, 0);
    step();
    in_valid = 1'b0;

    // Drain anything still queued
    ready_mode = 0;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check("drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
